// File: rtl/ram8_arbiter_pkg.sv
// Shared types and defaults for the ram8_arbiter slice.
// Optional power-on clear sweep is enabled with RAM8_ARB_CLEAR_EN.
package ram8_arbiter_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

endpackage

// File: rtl/ram8_arbiter_if.sv
// Requester-side bus of ram8_arbiter: two req/gnt ports A and B.
// master = requesters, slave = arbiter.
interface ram8_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 3
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/ram8_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Bit 0 is requester A, bit 1 is requester B.
module rr_arb2
  import ram8_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  gnt_t       i_last_gnt,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11):
        o_gnt = (i_last_gnt == GNT_B) ? 2'b01 : 2'b10;
      (i_req == 2'b01): o_gnt = 2'b01;
      (i_req == 2'b10): o_gnt = 2'b10;
      default:          o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter/sequencer in front of a single 8x16 RAM port.
// RAM8_ARB_CLEAR_EN adds a post-reset zeroing sweep and a busy output.
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  ram8_arbiter_if.slave bus,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  output logic [AW-1:0] mem_address,
  input  logic [DW-1:0] mem_out
`ifdef RAM8_ARB_CLEAR_EN
  ,
  output logic          busy
`endif
);

  state_t        r_state;
  state_t        w_state_nxt;
  gnt_t          r_last_gnt;
  logic          w_serve;
  logic          w_clear;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_a_rd;
  logic          w_b_rd;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

`ifdef RAM8_ARB_CLEAR_EN
  logic [AW-1:0] r_clr_addr;
`endif

  // Reset overrides everything combinationally, including grants.
  assign w_serve = (r_state == ST_SERVE) && !reset;
  assign w_clear = (r_state == ST_CLEAR) && !reset;
  assign w_req   = {bus.b_req, bus.a_req} & {2{w_serve}};

  rr_arb2 u_arb (
    .i_req      (w_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt)
  );

  assign bus.a_gnt    = w_gnt[0];
  assign bus.b_gnt    = w_gnt[1];
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rdata  = r_b_rdata;

  assign w_a_rd = w_gnt[0] & ~bus.a_we;
  assign w_b_rd = w_gnt[1] & ~bus.b_we;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef RAM8_ARB_CLEAR_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_SERVE;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef RAM8_ARB_CLEAR_EN
    if (r_state == ST_CLEAR &&
        r_clr_addr == {AW{1'b1}})
      w_state_nxt = ST_SERVE;
`else
    w_state_nxt = ST_SERVE;
`endif
  end

`ifdef RAM8_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset)
      r_clr_addr <= '0;
    else if (r_state == ST_CLEAR)
      r_clr_addr <= r_clr_addr + 1'b1;
  end

  assign busy = w_clear;
`endif

  always_comb begin
    mem_in      = '0;
    mem_load    = 1'b0;
    mem_address = '0;
    unique case (1'b1)
      w_gnt[0]: begin
        mem_address = bus.a_addr;
        mem_load    = bus.a_we;
        mem_in      = bus.a_we ? bus.a_wdata : '0;
      end
      w_gnt[1]: begin
        mem_address = bus.b_addr;
        mem_load    = bus.b_we;
        mem_in      = bus.b_we ? bus.b_wdata : '0;
      end
      default: ;
    endcase
`ifdef RAM8_ARB_CLEAR_EN
    if (w_clear) begin
      mem_load    = 1'b1;
      mem_address = r_clr_addr;
      mem_in      = '0;
    end
`else
    if (w_clear)
      mem_load = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= GNT_B;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      if (w_gnt[0])
        r_last_gnt <= GNT_A;
      else if (w_gnt[1])
        r_last_gnt <= GNT_B;
      r_a_rvalid <= w_a_rd;
      r_b_rvalid <= w_b_rd;
      if (w_a_rd)
        r_a_rdata <= mem_out;
      if (w_b_rd)
        r_b_rdata <= mem_out;
    end
  end

endmodule
